// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, WB control bit positions,
// MEM-stage FSM encoding and the MEM/WB payload record.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int CNT_W  = 8;

    // Bit positions inside the 2-bit writeback control field.
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [WB_W-1:0]   ctl;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  dest;
    } mem_wb_t;

    function automatic logic misaligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. The payload only moves on ld; the valid bit
// follows ld every cycle so an unloaded slot turns into a bubble.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    ld,
    input  mem_wb_t d,
    output logic    wb_valid,
    output mem_wb_t q
);

    logic    wb_valid_q;
    mem_wb_t q_q;
    mem_wb_t q_d;

    always_comb begin
        q_d = q_q;
        if (ld) q_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            q_q        <= '0;
        end else begin
            wb_valid_q <= ld;
            q_q        <= q_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign q        = q_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request per memory instruction,
// stalls upstream until ack or timeout, and loads the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WB_W-1:0]   wb_ctl,
    input  logic              branch,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] add_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [REG_W-1:0]  dest_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              wb_valid,
    output logic [WB_W-1:0]   wb_ctlout,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  wb_dest,
    output logic              mem_err
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_err_q, mem_err_d;

    logic    start, bad, good_start, time_up, done;
    logic    wb_ld;
    mem_wb_t wb_d, wb_q;

    assign start      = in_valid & (memread | memwrite);
    assign bad        = misaligned(alu_result) | (memread & memwrite);
    assign good_start = start & ~bad;
    assign time_up    = (cnt_q == CNT_LIM);
    // Ack on the limit cycle wins: done covers both, error only without ack.
    assign done       = mem_ack | time_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (good_start) state_d = ST_ACCESS;
            ST_ACCESS: if (done)       state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request registers are frozen for the whole access.
    always_comb begin
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == ST_IDLE) begin
            if (good_start) begin
                cnt_d       = '0;
                mem_req_d   = 1'b1;
                mem_we_d    = memwrite;
                mem_addr_d  = alu_result;
                mem_wdata_d = rdata2;
            end
        end else if (done) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        stall      = 1'b0;
        wb_ld      = 1'b0;
        mem_err_d  = 1'b0;
        wb_d.ctl   = wb_ctl;
        wb_d.rdata = '0;
        wb_d.alu   = alu_result;
        wb_d.dest  = dest_reg;
        if (state_q == ST_IDLE) begin
            stall     = good_start;
            wb_ld     = in_valid & ~good_start;
            mem_err_d = start & bad;
        end else begin
            stall     = 1'b1;
            wb_ld     = done;
            mem_err_d = ~mem_ack & time_up;
            if (mem_ack) wb_d.rdata = mem_rdata;
        end
        if (mem_err_d) begin
            wb_d.ctl[WB_REGWRITE] = 1'b0;
            wb_d.ctl[WB_MEMTOREG] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_err_q   <= mem_err_d;
        end
    end

    mem_wb_reg u_mem_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (wb_ld),
        .d        (wb_d),
        .wb_valid (wb_valid),
        .q        (wb_q)
    );

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_err       = mem_err_q;
    assign pcsrc         = in_valid & branch & zero & ~stall;
    assign branch_target = add_result;
    assign wb_ctlout     = wb_q.ctl;
    assign read_data     = wb_q.rdata;
    assign alu_out       = wb_q.alu;
    assign wb_dest       = wb_q.dest;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, 16, max cycles mem_req is held without mem_ack before abort (range 2..255).
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  EX/MEM slot holds a live instruction.
REQ-005 wb_ctl  in  2  writeback control from EX/MEM, passed to MEM/WB.
REQ-006 branch, memread, memwrite  in  1 each  MEM control from EX/MEM.
REQ-007 add_result  in  32  branch target from EX/MEM.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 alu_result  in  32  ALU result / memory byte address.
REQ-010 rdata2  in  32  store data.
REQ-011 dest_reg  in  5  destination register number.
REQ-012 mem_req, mem_we  out  1 each  data-memory request and write-enable.
REQ-013 mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-014 mem_ack  in  1  memory completion, one-cycle pulse.
REQ-015 mem_rdata  in  32  read data, valid with mem_ack.
REQ-016 stall  out  1  upstream holds EX/MEM contents while high.
REQ-017 pcsrc  out  1  take branch; branch_target  out  32  equals add_result.
REQ-018 wb_valid, wb_ctlout[2], read_data[32], alu_out[32], wb_dest[5]  out  registered MEM/WB outputs.
REQ-019 mem_err  out  1  one-cycle pulse on misaligned, illegal, or timed-out access.

Function
REQ-020 FSM states IDLE and ACCESS; reset state IDLE.
REQ-021 Access start = in_valid & (memread | memwrite) in IDLE.
REQ-022 Start with alu_result[1:0]==0 and not both memread/memwrite: go to ACCESS, mem_req=1 from next cycle, mem_we=memwrite, mem_addr=alu_result, mem_wdata=rdata2 registered at start.
REQ-023 mem_req, mem_we, mem_addr, mem_wdata SHALL remain constant while in ACCESS until ack or abort.
REQ-024 stall SHALL be combinational: high on a valid start cycle in IDLE, and in ACCESS until the cycle mem_ack=1 or timeout occurs.
REQ-025 ACCESS with mem_ack=1: capture mem_rdata into read_data; load MEM/WB with wb_valid=1; drop mem_req next cycle; return to IDLE.
REQ-026 Timeout counter clears on entering ACCESS, increments each ACCESS cycle without ack; at count TIMEOUT-1 without ack: abort, mem_err=1, wb_valid=1 with wb_ctlout=0, return to IDLE.
REQ-027 mem_ack arriving in the same cycle as the timeout limit SHALL count as success (ack wins).
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 Misaligned address, or memread & memwrite both high: no request, mem_err pulse, wb_valid=1 with wb_ctlout=0, no stall, 1-cycle latency.
REQ-030 Non-memory valid instruction: MEM/WB loads next edge, wb_valid=1, read_data=0; latency 1 cycle.
REQ-031 in_valid=0 and not stalled: wb_valid=0 next cycle; other MEM/WB fields hold.
REQ-032 alu_out, wb_dest, wb_ctlout SHALL equal their EX/MEM values sampled when the slot completes.
REQ-033 pcsrc = in_valid & branch & zero & ~stall, combinational; never asserted for a memory instruction still stalling.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, mem_err=0, and all MEM/WB outputs to 0.
REQ-035 Reset during ACCESS SHALL abandon the access; a later mem_ack SHALL be ignored.
REQ-036 First valid cycle after rst_n rises SHALL be handled as IDLE.

Structure
REQ-037 Shared package mips_pkg SHALL hold the FSM state encoding, the WB control bit positions, and the 32/5-bit width constants.
REQ-038 MEM/WB register SHALL be a sub-module mem_wb_reg with a load enable; FSM and timeout logic stay in mem_stage.

Verification
REQ-039 ALU op, alu_result=0x1234, dest_reg=7, wb_ctl=2'b10 -> next cycle wb_valid=1, alu_out=0x1234, wb_dest=7, stall=0, mem_req=0.
REQ-040 Load at addr 0x40, ack after 3 cycles with rdata 0xDEADBEEF -> stall high 4 cycles, mem_req stable 3 cycles, read_data=0xDEADBEEF, wb_valid=1 once.
REQ-041 Store addr 0x41 -> mem_req never rises, mem_err pulse, wb_ctlout=0, no stall.
REQ-042 Load with no ack, TIMEOUT=4 -> abort after 4 cycles, mem_err=1, wb_ctlout=0; ack at cycle 4 -> success instead.
REQ-043 branch=1, zero=1, add_result=0x100 -> pcsrc=1, branch_target=0x100 same cycle; zero=0 -> pcsrc=0.
REQ-044 rst_n low in cycle 2 of ACCESS -> mem_req=0 immediately; late mem_ack -> no wb_valid.
